fetch_buffer: RTL
=================

Name: fetch_buffer

Overview:
- Consumer side of the fetch address path. Takes PCF from the PC generator and issues instruction-memory requests. Collects in-order responses into a DEPTH-entry buffer and presents {instr, pc} to decode with a valid/stall handshake.
- Drives StallF back to the PC generator whenever a request cannot be accepted.
- Flushes all wrong-path work on PCSrcE.

Parameters:
- DEPTH, 4, buffer entries and the maximum number of requests in flight plus held; power of 2, at least 2.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- PCF  in  XLEN  current fetch PC from the PC generator
- PCSrcE  in  1  redirect/flush from execute
- StallF  out  1  hold PC; high when no request is accepted this cycle
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address (equals PCF)
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, latency 1 or more cycles
- imem_rdata  in  XLEN  response instruction
- ValidD  out  1  head entry holds a returned instruction
- InstrD  out  XLEN  head instruction; 32'h00000013 (NOP) when ValidD=0
- PCD  out  XLEN  head PC; 0 when ValidD=0
- PCPlus4D  out  XLEN  PCD+4, mod 2^XLEN
- StallD  in  1  decode not ready

Behaviour:
- Registered state:
  - circular buffer of DEPTH entries {pc, instr, filled}
  - head/tail/fill pointers
  - count (allocated entries)
  - drop_cnt (stale responses still to discard)
- Credit: credit = (count + drop_cnt < DEPTH), computed from registered values only. A pop in the same cycle does not free credit.
- Request:
  - imem_req = !rst && !PCSrcE && credit; imem_addr = PCF.
  - Issue = imem_req && imem_gnt.
  - On issue, allocate the entry at tail: pc=PCF, filled=0; tail++, count++.
- StallF = !PCSrcE && !issue.
  - StallF must be low while PCSrcE is high, so the PC generator loads PCTargetE. Its stall has priority over redirect.
- Response on imem_rvalid:
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Else: write instr into the entry at the fill pointer, set filled=1, fill++.
  - rvalid while drop_cnt=0 and no unfilled entry is a protocol error. It is ignored (see optional feature).
- Decode:
  - ValidD = count>0 && head.filled.
  - Pop when ValidD && !StallD && !PCSrcE: head++, count--.
  - Outputs are driven combinationally from head; latency from response to ValidD is 1 cycle.
- Flush (PCSrcE=1 at an edge):
  - Clear all entries and pointers; count=0.
  - drop_cnt_next = drop_cnt + unfilled − (rvalid ? 1 : 0).
  - Filled entries are discarded, not popped. No request issues in the flush cycle.
- Simultaneous events:
  - Issue, response and pop may all occur in one cycle; count_next = count + issue − pop.
  - Response into the entry being allocated in the same cycle is impossible (latency is at least 1).
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full is count==DEPTH; empty is count==0.
- Reset:
  - count=0, drop_cnt=0, pointers=0.
  - ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=4, imem_req=0, StallF=1.
  - Reset mid-transaction drops in-flight responses. The memory is reset with the same rst.

Optional Feature:
- FETCH_ERR_CHECK_EN
  - Defined: adds output imem_err (1 bit, reset 0), set sticky on an unexpected rvalid (drop_cnt=0 and no unfilled entry) or on drop_cnt overflow. Cleared only by rst.
  - Undefined: port absent; unexpected responses are silently ignored.

Decomposition:
- Package fetch_pkg:
  - XLEN default
  - NOP_INSTR = 32'h00000013
  - entry struct {pc, instr, filled}
  - pointer-width function clog2
- One sub-module, fetch_entry_fifo: entry storage, head/tail/fill pointers and count, with alloc/fill/pop/clear strobes.
- The top level owns credit, handshake and drop_cnt logic.

Test Plan:
- Reset, then imem_gnt=1 with 1-cycle latency and StallD=0 -> ValidD high from cycle 2. PCD runs 0,4,8,…; InstrD matches memory; StallF=0 every cycle.
- StallD=1 held with DEPTH=4 -> exactly 4 issues, then StallF=1 and imem_req=0. Release StallD -> one pop per cycle, and requests resume the cycle after count drops.
- imem_gnt=0 for 3 cycles -> StallF=1 for 3 cycles, PCF held, no allocation.
- Memory latency 3, PCSrcE pulsed with 2 requests in flight and 1 filled entry -> ValidD=0 next cycle, StallF=0 during flush, and the next 2 responses are discarded (drop_cnt 2->0). The first instruction presented has PC=PCTargetE.
- Flush in the same cycle as an rvalid and a pop attempt -> no pop, drop_cnt = unfilled−1, buffer empty.
- With FETCH_ERR_CHECK_EN defined, inject rvalid with an empty buffer -> imem_err=1 and stays 1 until rst; buffer unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch buffer slice.
// Pure declarations; no timing involved.
// No flow control here; consumers own backpressure.
package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
        logic                filled;
    } entry_t;

    // Pointer width for a power-of-two depth (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_entry_fifo.sv
// Circular entry store: allocate at tail, fill at fill pointer, pop at head.
// Latency: state updates on the clock edge; head view is combinational from registers.
// No internal backpressure: caller guarantees alloc only with space and fill only with an unfilled entry.
module fetch_entry_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF,
    localparam int PW   = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_alloc,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_fill,
    input  logic [XLEN-1:0] i_fill_instr,
    input  logic            i_pop,
    output logic [PW:0]     o_count,
    output logic [PW:0]     o_unfilled,
    output logic            o_head_filled,
    output logic [XLEN-1:0] o_head_pc,
    output logic [XLEN-1:0] o_head_instr
);

    logic [XLEN-1:0]  r_pc    [DEPTH];
    logic [XLEN-1:0]  r_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    r_fill;
    logic [PW:0]      r_count;
    logic [PW:0]      r_unfilled;

    // Pointer, occupancy and filled-flag bookkeeping; clear wipes all allocations.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_filled   <= '0;
        end else begin
            // Alloc and fill never target the same slot: fill only touches entries allocated earlier.
            if (i_alloc) begin
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + PW'(1);
            end
            if (i_fill) begin
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count    <= r_count + (PW+1)'(i_alloc) - (PW+1)'(i_pop);
            r_unfilled <= r_unfilled + (PW+1)'(i_alloc) - (PW+1)'(i_fill);
        end
    end

    // Payload storage; contents of free slots are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (i_alloc) r_pc[r_tail]    <= i_alloc_pc;
        if (i_fill)  r_instr[r_fill] <= i_fill_instr;
    end

    assign o_count       = r_count;
    assign o_unfilled    = r_unfilled;
    assign o_head_filled = r_filled[r_head];
    assign o_head_pc     = r_pc[r_head];
    assign o_head_instr  = r_instr[r_head];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch request issue plus in-order response buffer toward decode; FETCH_ERR_CHECK_EN adds sticky imem_err.
// Latency: response to ValidD is 1 cycle; request issue is combinational from PCF.
// Backpressure: StallF holds the PC when credit is exhausted or imem_gnt is low; StallD holds the head entry.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    input  logic            PCSrcE,
    output logic            StallF,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
`ifdef FETCH_ERR_CHECK_EN
    output logic            imem_err,
`endif
    input  logic            StallD
);

    localparam int PW = clog2(DEPTH);

    logic [PW:0]     w_count;
    logic [PW:0]     w_unfilled;
    logic            w_head_filled;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_instr;
    logic [PW+1:0]   w_occ;
    logic            w_credit;
    logic            w_issue;
    logic            w_pop;
    logic            w_drop;
    logic            w_fill;
    logic            w_rsp_used;
    logic [PW:0]     w_drop_flush;
    logic [PW:0]     r_drop_cnt;

    // Stale responses still owed by memory count against credit so a flush can never oversubscribe the buffer.
    assign w_occ    = {1'b0, w_count} + {1'b0, r_drop_cnt};
    assign w_credit = w_occ < (PW+2)'(DEPTH);

    assign imem_req  = !rst && !PCSrcE && w_credit;
    assign imem_addr = PCF;
    assign w_issue   = imem_req && imem_gnt;
    assign StallF    = !PCSrcE && !w_issue;

    assign w_drop     = imem_rvalid && (r_drop_cnt != '0);
    assign w_fill     = imem_rvalid && (r_drop_cnt == '0) && (w_unfilled != '0) && !PCSrcE;
    assign w_rsp_used = imem_rvalid && ((r_drop_cnt != '0) || (w_unfilled != '0));
    assign w_drop_flush = r_drop_cnt + w_unfilled - {{PW{1'b0}}, w_rsp_used};

    assign ValidD   = (w_count != '0) && w_head_filled;
    assign w_pop    = ValidD && !StallD && !PCSrcE;
    assign InstrD   = ValidD ? w_head_instr : XLEN'(NOP_INSTR);
    assign PCD      = ValidD ? w_head_pc : '0;
    assign PCPlus4D = PCD + XLEN'(4);

    fetch_entry_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_entries (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (PCSrcE),
        .i_alloc       (w_issue),
        .i_alloc_pc    (PCF),
        .i_fill        (w_fill),
        .i_fill_instr  (imem_rdata),
        .i_pop         (w_pop),
        .o_count       (w_count),
        .o_unfilled    (w_unfilled),
        .o_head_filled (w_head_filled),
        .o_head_pc     (w_head_pc),
        .o_head_instr  (w_head_instr)
    );

    // On flush every outstanding unfilled request becomes a response to discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (PCSrcE) begin
            r_drop_cnt <= w_drop_flush;
        end else if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - (PW+1)'(1);
        end
    end

`ifdef FETCH_ERR_CHECK_EN
    logic [PW+1:0] w_drop_sum;
    logic          w_unexp;
    logic          w_ovf;
    logic          r_imem_err;

    assign w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_unfilled} - {{(PW+1){1'b0}}, w_rsp_used};
    assign w_unexp    = imem_rvalid && (r_drop_cnt == '0) && (w_unfilled == '0);
    assign w_ovf      = PCSrcE && (w_drop_sum > (PW+2)'(DEPTH));

    // Sticky protocol-error flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imem_err <= 1'b0;
        end else if (w_unexp || w_ovf) begin
            r_imem_err <= 1'b1;
        end
    end

    assign imem_err = r_imem_err;
`endif

endmodule
